// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: drains a 1-cycle-latency FIFO read port and unpacks each IN_WIDTH word into
// NUM_BEATS = IN_WIDTH/OUT_WIDTH beats on a valid/ready stream, least-significant slice first.
// A 2-entry word buffer hides the read latency so one beat per cycle is sustained.
//
// Optional feature macro: FIFO_RD_UNPACK_LAST_EN (transfer length, m_last and done).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   fifo_read_req       pop request (out), qualified by fifo_read_ready
//   fifo_read_ready     FIFO non-empty (in)
//   fifo_read_data      word returned the cycle after an accepted pop (in)
//   m_valid/m_ready     output stream handshake
//   m_data              current beat
//   start, cfg_num_words, m_last, done   only with FIFO_RD_UNPACK_LAST_EN
module fifo_rd_unpack #(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 fifo_read_req,
  input  logic                 fifo_read_ready,
  input  logic [IN_WIDTH-1:0]  fifo_read_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data
`ifdef FIFO_RD_UNPACK_LAST_EN
  ,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_num_words,
  output logic                 m_last,
  output logic                 done
`endif
);

  localparam int unsigned NumBeats = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || NumBeats < 1 || LEN_WIDTH < 1) begin : gen_bad_params
    $error("fifo_rd_unpack: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] buf_q [2];
  logic [IN_WIDTH-1:0] buf_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ_q, occ_d;
  logic                pend_q, pend_d;
  logic [BeatW-1:0]    beat_q, beat_d;

  logic                allowed;
  logic                handshake;
  logic                pop_now;
  logic [IN_WIDTH-1:0] head;

  assign head = buf_q[rd_ptr_q];

  always_comb begin
    m_valid   = (occ_q != 2'd0);
    handshake = m_valid && m_ready;
    pop_now   = handshake && (beat_q == LastBeat);
    // occ + pend never exceeds 2; a head pop this cycle frees a slot for the new request.
    // The m_ready -> fifo_read_req combinational path is deliberate.
    fifo_read_req = !reset && allowed && fifo_read_ready &&
                    (({1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_now}) < 3'd2);
  end

  always_comb begin
    m_data = '0;
    for (int i = 0; i < NumBeats; i++) begin
      if (beat_q == BeatW'(i)) m_data = head[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    pend_d   = fifo_read_req;  // req already includes fifo_read_ready
    occ_d    = occ_q + {1'b0, pend_q} - {1'b0, pop_now};
    // The returning word always lands in the free slot, never on the head.
    if (pend_q) begin
      buf_d[wr_ptr_q] = fifo_read_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (handshake) begin
      if (pop_now) begin
        beat_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      pend_q   <= 1'b0;
      beat_q   <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pend_q   <= pend_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_RD_UNPACK_LAST_EN
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;  // words still to be emitted
  logic                 zero_done_q, zero_done_d;  // done pulse for a zero-length start

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      issued_q    <= '0;
      remaining_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      remaining_q <= remaining_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_num_words == '0) begin
            zero_done_d = 1'b1;
          end else begin
            count_d     = cfg_num_words;
            issued_d    = '0;
            remaining_d = cfg_num_words;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (fifo_read_req) issued_d = issued_q + 1'b1;
        if (pop_now) begin
          remaining_d = remaining_q - 1'b1;
          if (m_last) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    allowed = (state_q == StRun) && (issued_q < count_q);
    m_last  = m_valid && (state_q == StRun) && (remaining_q == LEN_WIDTH'(1)) &&
              (beat_q == LastBeat);
    done    = (state_q == StDone) || zero_done_q;
  end
`else
  assign allowed = 1'b1;
`endif

endmodule

// File: tb/tb_fifo_rd_unpack.sv
module tb_fifo_rd_unpack;
  localparam int unsigned IW = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned NB = IW / OW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          fifo_read_req, fifo_read_ready;
  logic [IW-1:0] fifo_read_data;
  logic          m_valid, m_ready;
  logic [OW-1:0] m_data;
  // NUM_BEATS = 1 instance
  logic          n1_req, n1_ready, n1_valid, n1_m_ready;
  logic [15:0]   n1_data, n1_m_data;
`ifdef FIFO_RD_UNPACK_LAST_EN
  logic          start, m_last, done, n1_start, n1_last, n1_done;
  logic [15:0]   cfg_num_words, n1_cfg;
`endif

  fifo_rd_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .fifo_read_req(fifo_read_req), .fifo_read_ready(fifo_read_ready),
    .fifo_read_data(fifo_read_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_RD_UNPACK_LAST_EN
    , .start(start), .cfg_num_words(cfg_num_words), .m_last(m_last), .done(done)
`endif
  );

  fifo_rd_unpack #(.IN_WIDTH(16), .OUT_WIDTH(16), .LEN_WIDTH(16)) u_nb1 (
    .clk(clk), .reset(reset), .fifo_read_req(n1_req), .fifo_read_ready(n1_ready),
    .fifo_read_data(n1_data), .m_valid(n1_valid), .m_ready(n1_m_ready), .m_data(n1_m_data)
`ifdef FIFO_RD_UNPACK_LAST_EN
    , .start(n1_start), .cfg_num_words(n1_cfg), .m_last(n1_last), .done(n1_done)
`endif
  );

  // Behavioural FIFO and expected-beat model for the main instance
  logic [IW-1:0] fq [$];
  logic [OW-1:0] exp_q [$];
  int push_total = 0, pop_total = 0, hs_total = 0, cyc = 0, last_pop_cyc = -1;
  int pop_base = 0, hs_base = 0;
  logic fifo_en;
  int pass_cnt = 0, chk_cnt = 0;

  assign fifo_read_ready = fifo_en && (push_total != pop_total);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_req && fifo_read_ready) begin
      fifo_read_data <= fq.pop_front();
      pop_total      <= pop_total + 1;
      last_pop_cyc   <= cyc;
    end else begin
      fifo_read_data <= {$urandom, $urandom};
    end
    if (m_valid && m_ready) hs_total <= hs_total + 1;
  end

  // Model for the NUM_BEATS = 1 instance: 8 preloaded words
  logic [15:0] n1_words [8];
  int n1_idx = 0, n1_hs = 0;
  logic n1_en;
  assign n1_ready = n1_en && (n1_idx < 8);

  always @(posedge clk) begin
    if (reset) begin
      n1_idx <= 0;
      n1_hs  <= 0;
    end else begin
      if (n1_req && n1_ready) begin
        n1_data <= n1_words[n1_idx[2:0]];
        n1_idx  <= n1_idx + 1;
      end
      if (n1_valid && n1_m_ready) n1_hs <= n1_hs + 1;
    end
  end

  task automatic push_word(input logic [IW-1:0] w);
    fq.push_back(w);
    push_total++;
    for (int i = 0; i < NB; i++) exp_q.push_back(OW'(w >> (i * OW)));
  endtask

  task automatic flush_model();
    fq.delete();
    exp_q.delete();
    push_total = pop_total;
    pop_base   = pop_total;
    hs_base    = hs_total;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; m_ready = 1'b0; fifo_en = 1'b0; n1_en = 1'b0; n1_m_ready = 1'b0;
`ifdef FIFO_RD_UNPACK_LAST_EN
    start = 1'b0; n1_start = 1'b0;
`endif
    repeat (2) @(negedge clk);
    flush_model();
    reset = 1'b0;
  endtask

`ifdef FIFO_RD_UNPACK_LAST_EN
  task automatic kick(input int n);
    @(negedge clk);
    cfg_num_words = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
`endif

  task automatic test_reset();
    // Reset held with the FIFO non-empty and downstream ready: nothing may move.
    push_word(64'h0123_4567_89ab_cdef);
    fifo_en = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid);
    else pass_cnt++;
    chk_cnt++; if (m_data !== '0) $display("FAIL reset_data: got %h want 0", m_data);
    else pass_cnt++;
    chk_cnt++; if (fifo_read_req !== 1'b0) $display("FAIL reset_req: got %b want 0", fifo_read_req);
    else pass_cnt++;
`ifdef FIFO_RD_UNPACK_LAST_EN
    chk_cnt++; if (m_last !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_last_done: got %b%b want 00", m_last, done);
    else pass_cnt++;
`endif
  endtask

  task automatic test_first_beat();
    do_reset();
    push_word(64'h4444_3333_2222_1111);
    m_ready = 1'b1;
`ifdef FIFO_RD_UNPACK_LAST_EN
    kick(1);
`endif
    fifo_en = 1'b1;
    for (int t = 0; t < 10 && !m_valid; t++) @(negedge clk);
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL first_valid_timeout: got %b want 1", m_valid);
    else pass_cnt++;
    chk_cnt++; if (cyc - last_pop_cyc != 2)
      $display("FAIL first_latency: got %0d want 2 cycles", cyc - last_pop_cyc);
    else pass_cnt++;
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0])
        $display("FAIL first_beat%0d: got v=%b %h want v=1 %h", i, m_valid, m_data, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL first_drained: got %b want 0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_nb1_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) n1_words[i] = 16'($urandom);
`ifdef FIFO_RD_UNPACK_LAST_EN
    @(negedge clk); n1_cfg = 16'd8; n1_start = 1'b1;
    @(negedge clk); n1_start = 1'b0;
`endif
    n1_m_ready = 1'b1; n1_en = 1'b1;
    for (int t = 0; t < 10 && !n1_valid; t++) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (n1_valid !== 1'b1 || n1_m_data !== n1_words[i])
        $display("FAIL nb1_beat%0d: got v=%b %h want v=1 %h", i, n1_valid, n1_m_data, n1_words[i]);
      else pass_cnt++;
      chk_cnt++;
      if (n1_idx - n1_hs > 2) $display("FAIL nb1_occ: got %0d want <=2", n1_idx - n1_hs);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++; if (n1_valid !== 1'b0) $display("FAIL nb1_drained: got %b want 0", n1_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int pushed = 0;
    int t = 0;
    logic hold_prev = 1'b0;
    logic [OW-1:0] prev_data = '0;
    do_reset();
`ifdef FIFO_RD_UNPACK_LAST_EN
    kick(1000);
`endif
    fifo_en = 1'b1;
    while ((pushed < 1000 || exp_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
      if (hold_prev) begin
        chk_cnt++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          $display("FAIL rand_stable: got v=%b %h want v=1 %h", m_valid, m_data, prev_data);
        else pass_cnt++;
      end
      chk_cnt++;
      if ((pop_total - pop_base) - (hs_total - hs_base) / NB > 2)
        $display("FAIL rand_occ: got %0d want <=2", (pop_total - pop_base) - (hs_total - hs_base) / NB);
      else pass_cnt++;
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push_word({$urandom, $urandom});
        pushed++;
      end
      if (m_valid && m_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rand_extra_beat: got %h want none", m_data);
        else if (m_data !== exp_q[0])
          $display("FAIL rand_data: got %h want %h", m_data, exp_q[0]);
        else pass_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
    chk_cnt++; if (t >= 20000) $display("FAIL rand_timeout: got %0d beats left want 0", exp_q.size());
    else pass_cnt++;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rand_drained: got %b want 0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
`ifdef FIFO_RD_UNPACK_LAST_EN
    kick(8);
`endif
    for (int i = 0; i < 8; i++) push_word({$urandom, $urandom});
    fifo_en = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if ((pop_total - pop_base) != 2 || m_valid !== 1'b1)
      $display("FAIL mid_fill: got pops=%0d v=%b want pops=2 v=1", pop_total - pop_base, m_valid);
    else pass_cnt++;
    reset = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (m_valid !== 1'b0 || m_data !== '0 || fifo_read_req !== 1'b0)
      $display("FAIL mid_reset: got v=%b d=%h req=%b want 0 0 0", m_valid, m_data, fifo_read_req);
    else pass_cnt++;
    flush_model();
    fifo_en = 1'b0;
    reset = 1'b0;
    push_word(64'hdead_beef_cafe_f00d);
`ifdef FIFO_RD_UNPACK_LAST_EN
    kick(1);
`endif
    fifo_en = 1'b1;
    for (int t = 0; t < 10 && !m_valid; t++) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0])
        $display("FAIL mid_resume%0d: got v=%b %h want v=1 %h", i, m_valid, m_data, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
      @(negedge clk);
    end
  endtask

`ifdef FIFO_RD_UNPACK_LAST_EN
  task automatic test_last();
    int beats = 0, last_cyc = -1, done_cyc = -1, done_n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom});
    m_ready = 1'b1;
    @(negedge clk); cfg_num_words = 16'd3; start = 1'b1; fifo_en = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (done) begin done_n++; done_cyc = cyc; end
      if (m_valid && m_ready) begin
        beats++;
        chk_cnt++;
        if (m_data !== exp_q[0]) $display("FAIL last_data%0d: got %h want %h", beats, m_data, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
        chk_cnt++;
        if (m_last !== (beats == 12))
          $display("FAIL last_flag%0d: got %b want %b", beats, m_last, beats == 12);
        else pass_cnt++;
        if (beats == 12) last_cyc = cyc;
      end
      @(negedge clk);
    end
    chk_cnt++; if (pop_total - pop_base != 3) $display("FAIL last_pops: got %0d want 3", pop_total - pop_base);
    else pass_cnt++;
    chk_cnt++; if (beats != 12) $display("FAIL last_beats: got %0d want 12", beats);
    else pass_cnt++;
    chk_cnt++;
    if (done_n != 1 || done_cyc != last_cyc + 1)
      $display("FAIL last_done: got n=%0d at %0d want n=1 at %0d", done_n, done_cyc, last_cyc + 1);
    else pass_cnt++;
    chk_cnt++; if (fq.size() != 2) $display("FAIL last_left: got %0d want 2", fq.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    do_reset();
    push_word({$urandom, $urandom});
    fifo_en = 1'b1; m_ready = 1'b1;
    @(negedge clk); cfg_num_words = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (pop_total != pop_base || m_valid !== 1'b0)
      $display("FAIL zero_nopop: got pops=%0d v=%b want 0 0", pop_total - pop_base, m_valid);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1; m_ready = 1'b0; fifo_en = 1'b0; n1_en = 1'b0; n1_m_ready = 1'b0;
`ifdef FIFO_RD_UNPACK_LAST_EN
    start = 1'b0; cfg_num_words = '0; n1_start = 1'b0; n1_cfg = '0;
`endif
    test_reset();
    test_first_beat();
    test_nb1_back_to_back();
    test_random();
    test_reset_mid();
`ifdef FIFO_RD_UNPACK_LAST_EN
    test_last();
    test_zero_len();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
